// File: rtl/sram_like_arbiter.sv
// Merges the core's instruction and data SRAM-like masters onto one SRAM-like slave port.
// Data wins over inst, a grant is held until addr_ok, and responses follow an in-order owner FIFO.
module sram_like_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  output logic        resp_err
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

  // Owner encoding in the FIFO and lock register: 1 = data master, 0 = inst master.
  logic [CW-1:0]              count_q, count_d;
  logic [PW-1:0]              wptr_q, wptr_d, rptr_q, rptr_d;
  logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;
  logic                       lock_q, lock_d;
  logic                       lock_owner_q, lock_owner_d;
  logic                       resp_err_q, resp_err_d;

  logic sel_valid_s, sel_s, sel_req_s, full_s, sel_addr_ok_s, pop_s, head_owner_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PTR_LAST) begin
      next_ptr = {PW{1'b0}};
    end else begin
      next_ptr = p + PTR_ONE;
    end
  endfunction

  assign inst_rdata = rdata;
  assign data_rdata = rdata;
  assign resp_err   = resp_err_q;

  // Arbitration, slave-side request muxing and handshake routing
  always_comb begin
    sel_valid_s = 1'b0;
    sel_s       = 1'b0;
    if (lock_q) begin
      sel_valid_s = 1'b1;
      sel_s       = lock_owner_q;
    end else if (data_req) begin
      sel_valid_s = 1'b1;
      sel_s       = 1'b1;
    end else if (inst_req) begin
      sel_valid_s = 1'b1;
      sel_s       = 1'b0;
    end else begin
      sel_valid_s = 1'b0;
      sel_s       = 1'b0;
    end

    sel_req_s = sel_valid_s & (sel_s ? data_req : inst_req);
    full_s    = (count_q == CNT_FULL);
    req       = sel_req_s & ~full_s;

    if (sel_s) begin
      wr    = data_wr;
      size  = data_size;
      addr  = data_addr;
      wdata = data_wdata;
    end else begin
      wr    = inst_wr;
      size  = inst_size;
      addr  = inst_addr;
      wdata = inst_wdata;
    end

    sel_addr_ok_s = addr_ok & req;
    inst_addr_ok  = sel_addr_ok_s & ~sel_s;
    data_addr_ok  = sel_addr_ok_s & sel_s;

    pop_s        = data_ok & (count_q != {CW{1'b0}});
    head_owner_s = owner_q[rptr_q];
    inst_data_ok = pop_s & ~head_owner_s;
    data_data_ok = pop_s & head_owner_s;
  end

  // Next state for owner FIFO, grant lock and sticky error flag
  always_comb begin
    count_d      = count_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    owner_d      = owner_q;
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    resp_err_d   = resp_err_q | (data_ok & ~pop_s);

    if (sel_addr_ok_s) begin
      owner_d[wptr_q] = sel_s;
      wptr_d          = next_ptr(wptr_q);
    end else begin
      wptr_d = wptr_q;
    end

    if (pop_s) begin
      rptr_d = next_ptr(rptr_q);
    end else begin
      rptr_d = rptr_q;
    end

    case ({sel_addr_ok_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A stalled request keeps its grant so the slave sees a stable address until addr_ok.
    if (sel_addr_ok_s) begin
      lock_d = 1'b0;
    end else if (req && !addr_ok) begin
      lock_d       = 1'b1;
      lock_owner_d = sel_s;
    end else if (lock_q && !sel_req_s) begin
      lock_d = 1'b0;
    end else begin
      lock_d = lock_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= {CW{1'b0}};
      wptr_q       <= {PW{1'b0}};
      rptr_q       <= {PW{1'b0}};
      owner_q      <= {MAX_OUTSTANDING{1'b0}};
      lock_q       <= 1'b0;
      lock_owner_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      count_q      <= count_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      owner_q      <= owner_d;
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized scoreboard bench for sram_like_arbiter: an arbitration model checks the address
// phase each cycle and queues expected response owners; a monitor pops them on every response.
module tb_sram_like_arbiter;
  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0, inst_wr = 1'b0;
  logic [1:0]  inst_size = 2'd0;
  logic [31:0] inst_addr = 32'd0, inst_wdata = 32'd0, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = 2'd0;
  logic [31:0] data_addr = 32'd0, data_wdata = 32'd0, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata = 32'd0;
  logic        addr_ok = 1'b0, data_ok = 1'b0;
  logic        resp_err;

  sram_like_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  bit sb_q[$];        // expected response owners in order, 1 = data master
  bit exp_err = 1'b0;

  // Reference model state: outstanding count, pending (ungranted) owner, slave backlog
  int model_cnt = 0;
  bit pend_v = 1'b0, pend_o = 1'b0;
  int slave_pend = 0;
  int p_inst = 0, p_data = 0, p_aok = 0, p_dok = 0;
  bit spur = 1'b0;

  task automatic drive();
    if (!inst_req && int'($urandom_range(99)) < p_inst) begin
      inst_req = 1'b1; inst_wr = 1'($urandom); inst_size = 2'($urandom_range(2));
      inst_addr = $urandom; inst_wdata = $urandom;
    end
    if (!data_req && int'($urandom_range(99)) < p_data) begin
      data_req = 1'b1; data_wr = 1'($urandom); data_size = 2'($urandom_range(2));
      data_addr = $urandom; data_wdata = $urandom;
    end
    addr_ok = (int'($urandom_range(99)) < p_aok);
    data_ok = spur || (slave_pend > 0 && int'($urandom_range(99)) < p_dok);
    rdata   = $urandom;
  endtask

  task automatic check_addr(output bit acc, output bit acc_o);
    bit cand_v, cand_o, cand_req, ereq;
    logic [71:0] got, exp;
    if (pend_v) begin cand_v = 1'b1; cand_o = pend_o; end
    else if (data_req) begin cand_v = 1'b1; cand_o = 1'b1; end
    else if (inst_req) begin cand_v = 1'b1; cand_o = 1'b0; end
    else begin cand_v = 1'b0; cand_o = 1'b0; end
    cand_req = cand_v && (cand_o ? data_req : inst_req);
    ereq = cand_req && (model_cnt < MAXO);
    if (cand_o)
      exp = {ereq, data_wr, data_size, data_addr, data_wdata, 1'b0, ereq && addr_ok};
    else
      exp = {ereq, inst_wr, inst_size, inst_addr, inst_wdata, ereq && addr_ok, 1'b0};
    got = {req, wr, size, addr, wdata, inst_addr_ok, data_addr_ok};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL addr_phase @%0t: got %h expected %h", $time, got, exp);
    end
    acc = ereq && addr_ok;
    acc_o = cand_o;
    if (acc) pend_v = 1'b0;
    else if (ereq) begin pend_v = 1'b1; pend_o = cand_o; end
    else if (pend_v && !cand_req) pend_v = 1'b0;
  endtask

  task automatic step();
    bit acc, acc_o, dok;
    drive();
    @(negedge clk);
    check_addr(acc, acc_o);
    dok = data_ok;
    @(posedge clk);
    #1;
    if (dok && model_cnt > 0) model_cnt--;
    if (dok && slave_pend > 0) slave_pend--;
    if (acc) begin
      sb_q.push_back(acc_o);
      model_cnt++;
      slave_pend++;
      if (acc_o) data_req = 1'b0; else inst_req = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; inst_req = 1'b0; data_req = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; spur = 1'b0;
    sb_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_cnt = 0; pend_v = 1'b0;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    p_inst = 0; p_data = 0; p_aok = 100; p_dok = 100;
    while ((inst_req || data_req || slave_pend > 0) && n < 200) begin
      step();
      n++;
    end
    vectors++;
    if (inst_req || data_req || slave_pend > 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d still pending, required 0", slave_pend);
    end
  endtask

  // Response monitor: routes each slave data_ok to the expected owner
  initial begin
    bit eio, edo, spurious, o;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_err = 1'b0;
      end else begin
        eio = 1'b0; edo = 1'b0; spurious = 1'b0;
        if (data_ok) begin
          if (sb_q.size() == 0) spurious = 1'b1;
          else begin o = sb_q.pop_front(); eio = !o; edo = o; end
        end
        vectors++;
        if ({inst_data_ok, data_data_ok, resp_err} !== {eio, edo, exp_err}) begin
          miscompares++;
          $display("FAIL resp_route @%0t: got i/d/err=%b%b%b expected %b%b%b", $time,
                   inst_data_ok, data_data_ok, resp_err, eio, edo, exp_err);
        end
        if (data_ok) begin
          vectors++;
          if (inst_rdata !== rdata || data_rdata !== rdata) begin
            miscompares++;
            $display("FAIL rdata @%0t: got %h/%h expected %h", $time, inst_rdata, data_rdata, rdata);
          end
        end
        if (spurious) exp_err = 1'b1;
      end
    end
  end

  initial begin
    do_reset();
    repeat (2) step();

    // single inst read at the boot vector
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'hBFC00000;
    p_aok = 100; p_dok = 0;
    step();
    p_dok = 100;
    repeat (2) step();
    drain();

    // simultaneous requests: data first, then inst
    inst_req = 1'b1; inst_addr = 32'h00400000;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h80000010; data_wdata = 32'h12345678;
    p_aok = 100; p_dok = 0;
    repeat (2) step();
    drain();

    // lock hold: inst stalled, data arrives mid-stall
    inst_req = 1'b1; inst_addr = 32'hBFC00004; p_aok = 0; p_dok = 0;
    step();
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80000020;
    repeat (2) step();
    p_aok = 100;
    repeat (2) step();
    drain();

    // FIFO full stall, then refill after a response
    p_inst = 100; p_aok = 100; p_dok = 0;
    repeat (4) step();
    p_dok = 100;
    repeat (4) step();
    drain();

    // push and pop in the same cycle at count 1
    p_inst = 100; p_aok = 100; p_dok = 0;
    step();
    p_dok = 100;
    repeat (3) step();
    drain();

    // randomized traffic with a reset in the middle
    for (int blk = 0; blk < 30; blk++) begin
      p_inst = int'($urandom_range(100)); p_data = int'($urandom_range(100));
      p_aok = int'($urandom_range(100, 20)); p_dok = int'($urandom_range(100, 10));
      if (blk == 15) do_reset();
      repeat (100) step();
    end
    drain();

    // spurious response after a clean reset
    do_reset();
    step();
    spur = 1'b1;
    step();
    spur = 1'b0;
    repeat (3) step();
    do_reset();
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Merges the core's instruction and data SRAM-like master channels into a single SRAM-like master channel.
- Sits between the mips core and a single-port SRAM-like slave (cpu_axi_interface-style bridge or unified memory).
- Uses fixed priority (data over inst), with a grant lock while a request is pending.
- Routes responses in order using an owner FIFO that supports up to MAX_OUTSTANDING accepted-but-unanswered transactions.

Parameters:
- MAX_OUTSTANDING, 2: owner FIFO depth; legal range 1..4; pointers are clog2-sized, plus a separate count register.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- inst_req, inst_wr  in  1 each  inst master request and write flag.
- inst_size  in  2  inst transfer size: 0 = byte, 1 = half, 2 = word.
- inst_addr, inst_wdata  in  32 each  inst address and write data.
- inst_rdata  out  32  inst read data.
- inst_addr_ok, inst_data_ok  out  1 each  inst handshakes.
- data_req, data_wr, data_size, data_addr, data_wdata  in  1/1/2/32/32  data master request fields.
- data_rdata  out  32  data read data.
- data_addr_ok, data_data_ok  out  1 each  data handshakes.
- req, wr  out  1 each  slave request and write flag.
- size  out  2  slave transfer size.
- addr, wdata  out  32 each  slave address and write data.
- rdata  in  32  slave read data.
- addr_ok, data_ok  in  1 each  slave handshakes.
- resp_err  out  1  sticky flag: data_ok arrived with the owner FIFO empty.

Behaviour:
- Reset: FIFO count = 0, pointers = 0, lock = 0, lock_owner = 0 (inst), resp_err = 0.
  - All handshake outputs are 0 while count = 0 and no req is present.
  - rdata outputs pass through the slave rdata; they are not reset.
- Selection, combinational each cycle:
  - If lock = 1: sel = lock_owner.
  - Else if data_req: sel = DATA.
  - Else if inst_req: sel = INST.
  - Else: no selection.
- full = (count == MAX_OUTSTANDING).
- Slave request:
  - req = selected master's req AND !full.
  - wr, size, addr, wdata are muxed from the selected master; they are driven from inst when nothing is selected.
- Address handshake:
  - sel_addr_ok = addr_ok AND req.
  - Only the selected master's *_addr_ok is driven to sel_addr_ok; the other master's is 0.
- Grant lock:
  - When req = 1 and addr_ok = 0 at the clock edge: lock <= 1, lock_owner <= sel.
  - When sel_addr_ok = 1: lock <= 0.
  - While locked, a newly arriving data_req does not pre-empt a pending inst request. This keeps the slave's req/addr stable until addr_ok.
  - If the locked master drops req (protocol violation): lock <= 0 on the next edge.
- Owner FIFO:
  - Push sel on sel_addr_ok.
  - Pop on data_ok when count > 0; that same cycle, head owner's *_data_ok = 1 and the other's = 0.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - full blocks new requests even if a pop happens in the same cycle. Zero-latency refill when full is not required.
  - Pointers wrap modulo MAX_OUTSTANDING.
- Response routing:
  - inst_rdata = data_rdata = rdata.
  - Only the *_data_ok line qualifies the data.
- Spurious data_ok (count = 0):
  - Both *_data_ok = 0, FIFO untouched.
  - resp_err <= 1 and stays set until rst.
- Latency:
  - Address channel is zero-cycle combinational pass-through.
  - Response is zero-cycle routed.
  - The arbiter adds no wait states beyond the FIFO-full stall.
- Reset mid-operation:
  - Outstanding entries are discarded.
  - Slave responses arriving after rst deassertion count as spurious and set resp_err.

Test Plan:
- Single inst read: inst_req = 1, addr = 0xBFC00000; slave addr_ok same cycle, data_ok 1 cycle later with rdata = 0x3C080001.
  - Expect addr = 0xBFC00000, inst_addr_ok = 1, then inst_data_ok = 1 and inst_rdata = 0x3C080001.
  - Expect data_addr_ok = data_data_ok = 0 throughout.
- Simultaneous requests, no lock:
  - Stimulus: inst_req and data_req both 1, data_addr = 0x80000010, data_wr = 1, size = 2, slave addr_ok = 1.
  - Expect a data grant first: wr = 1, addr = 0x80000010.
  - Expect inst granted the next cycle.
  - Expect responses routed data then inst, in order.
- Lock hold:
  - Stimulus: inst_req with slave addr_ok = 0 for 3 cycles; data_req rises in cycle 2.
  - Expect addr to stay at the inst address and data_addr_ok = 0 until inst_addr_ok.
  - Expect the data grant on the following cycle.
- FIFO full (MAX_OUTSTANDING = 2): three back-to-back inst requests with addr_ok = 1 and no data_ok.
  - Expect the third request to see req = 0.
  - On the first data_ok: count goes 2→1; the third request is accepted the next cycle.
- Same-cycle push/pop at count = 1: data_ok and new sel_addr_ok in the same cycle.
  - Expect count to stay 1, head owner receives data_ok, new owner enqueued.
- Spurious response: data_ok = 1 with count = 0.
  - Expect inst_data_ok = data_data_ok = 0 and resp_err = 1, held until rst.
  - After rst, expect resp_err = 0 and count = 0.
